// File: rtl/gcd_job_dispatcher_pkg.sv
// Shared types for the gcd job dispatcher.
//   GCD_W        : operand/result width of the gcd core
//   disp_state_t : dispatcher FSM states
//   gcd_pair_t   : one queued operand pair {a, b}
package gcd_job_dispatcher_pkg;

    localparam int unsigned GCD_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp
    } disp_state_t;

    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_job_dispatcher_if.sv
// Bundle of every handshake/bus signal around the dispatcher.
//   req_*   : operand pair request port (valid/ready)
//   start, a_in, b_in, done, result : gcd core launch/completion port
//   rsp_*   : response port (valid/ready)
//   busy    : dispatcher has queued or in-flight work
// Modports: master = environment (request source, gcd core, response sink),
//           slave  = the dispatcher itself.
interface gcd_job_dispatcher_if #(
    parameter int unsigned W = 32
) ();

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         done;
    logic [W-1:0] result;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_a;
    logic [W-1:0] rsp_b;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;

    logic         busy;

    modport master (
        output req_valid, req_a, req_b, done, result, rsp_ready,
        input  req_ready, start, a_in, b_in, rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, done, result, rsp_ready,
        output req_ready, start, a_in, b_in, rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_err, busy
    );

endinterface

// File: rtl/gcd_job_dispatcher_req_fifo.sv
// Request FIFO for the gcd job dispatcher: DEPTH entries of WIDTH bits, strict order.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: write one entry (ignored when full)
//   i_pop, o_rdata : o_rdata is the current head; i_pop advances it (ignored when empty)
//   o_full, o_empty, o_count : occupancy derived from the registered count
module gcd_job_dispatcher_req_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CntW-1:0]  o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CntW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_job_dispatcher.sv
// Upstream feeder for a gcd core. Queues operand pairs, launches one gcd job at a time,
// waits for done (guarded by a watchdog) and returns {a, b, gcd, err} on a response port.
// Pairs with a zero operand bypass the core and answer a|b directly.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (shared with the gcd core)
//   bus            : slave side of gcd_job_dispatcher_if (request, core, response, busy)
// Parameters: W operand width, DEPTH request FIFO entries (power of 2, >= 2),
//             TIMEOUT number of WAIT cycles before a job is aborted with err=1.
module gcd_job_dispatcher
    import gcd_job_dispatcher_pkg::*;
#(
    parameter int unsigned W       = GCD_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    gcd_job_dispatcher_if.slave   bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
    // Watchdog value seen on the last permitted WAIT cycle.
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    disp_state_t     r_state;
    logic            r_start;
    logic [W-1:0]    r_a_in;
    logic [W-1:0]    r_b_in;
    logic            r_rsp_valid;
    logic [W-1:0]    r_rsp_a;
    logic [W-1:0]    r_rsp_b;
    logic [W-1:0]    r_rsp_gcd;
    logic            r_rsp_err;
    logic [WdW-1:0]  r_wdog;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CntW-1:0] w_count;
    logic [2*W-1:0]  w_head;
    logic [W-1:0]    w_head_a;
    logic [W-1:0]    w_head_b;

    assign w_push   = bus.req_valid && !w_full;
    assign w_pop    = (r_state == StIdle) && !w_empty;
    assign w_head_a = w_head[2*W-1:W];
    assign w_head_b = w_head[W-1:0];

    gcd_job_dispatcher_req_fifo #(
        .WIDTH (2 * W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata ({bus.req_a, bus.req_b}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_start     <= 1'b0;
            r_a_in      <= '0;
            r_b_in      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_a     <= '0;
            r_rsp_b     <= '0;
            r_rsp_gcd   <= '0;
            r_rsp_err   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        if ((w_head_a == '0) || (w_head_b == '0)) begin
                            // gcd(x, 0) = x and gcd(0, 0) = 0, so a|b is the answer.
                            r_rsp_a     <= w_head_a;
                            r_rsp_b     <= w_head_b;
                            r_rsp_gcd   <= w_head_a | w_head_b;
                            r_rsp_err   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end else begin
                            r_a_in  <= w_head_a;
                            r_b_in  <= w_head_b;
                            r_start <= 1'b1;
                            r_state <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    r_start <= 1'b0;
                    r_wdog  <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    // done wins over a watchdog expiry in the same cycle.
                    if (bus.done) begin
                        r_rsp_a     <= r_a_in;
                        r_rsp_b     <= r_b_in;
                        r_rsp_gcd   <= bus.result;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else if (r_wdog == WdLast) begin
                        r_rsp_a     <= r_a_in;
                        r_rsp_b     <= r_b_in;
                        r_rsp_gcd   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.start     = r_start;
    assign bus.a_in      = r_a_in;
    assign bus.b_in      = r_b_in;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_a     = r_rsp_a;
    assign bus.rsp_b     = r_rsp_b;
    assign bus.rsp_gcd   = r_rsp_gcd;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (r_state != StIdle) || (w_count != '0);

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Self-checking bench for gcd_job_dispatcher: directed scenarios plus a randomized run,
// with a behavioural gcd core and a response scoreboard fed from the accepted requests.
module tb_gcd_job_dispatcher;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_job_dispatcher_if #(.W(32)) bus ();

    gcd_job_dispatcher #(
        .W       (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] g;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural gcd core ----------------
    int          core_delay = 3;
    bit          core_never = 1'b0;
    bit          spur = 1'b0;
    logic        core_done;
    logic [31:0] core_res;
    int          core_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b0;
            core_res  <= '0;
            core_cnt  <= 0;
        end else begin
            core_done <= 1'b0;
            if (bus.start && !core_never) begin
                core_cnt <= core_delay;
                core_res <= ref_gcd(bus.a_in, bus.b_in);
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) core_done <= 1'b1;
            end
        end
    end

    assign bus.done   = core_done | spur;
    assign bus.result = spur ? 32'd99 : core_res;

    // ---------------- response-ready source ----------------
    bit   rand_rdy = 1'b0;
    logic rdy_fix = 1'b1;
    logic rdy_rnd = 1'b1;
    always @(posedge clk) begin
        #2;
        rdy_rnd = 1'($urandom_range(0, 1));
    end
    assign bus.rsp_ready = rand_rdy ? rdy_rnd : rdy_fix;

    // ---------------- monitors / scoreboard (sample on negedge) ----------------
    int          start_cnt = 0;
    int          rsp_cnt = 0;
    logic        prev_start = 1'b0;
    bit          in_job = 1'b0;
    logic [31:0] rec_a, rec_b;
    logic [31:0] last_gcd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0;
            in_job     = 1'b0;
        end else begin
            if (bus.start) begin
                start_cnt++;
                check("start_single_cycle", 32'(prev_start), 32'd0);
                rec_a  = bus.a_in;
                rec_b  = bus.b_in;
                in_job = 1'b1;
            end else if (in_job) begin
                check("a_in_stable", bus.a_in, rec_a);
                check("b_in_stable", bus.b_in, rec_b);
                if (bus.rsp_valid) in_job = 1'b0;
            end
            prev_start = bus.start;
            if (bus.rsp_valid && bus.rsp_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rsp_unexpected: observed gcd %0d expected no response",
                           bus.rsp_gcd);
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_a", bus.rsp_a, e.a);
                    check("rsp_b", bus.rsp_b, e.b);
                    check("rsp_gcd", bus.rsp_gcd, e.g);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.e));
                end
                last_gcd = bus.rsp_gcd;
                rsp_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer (a,b); returns just after the accepting edge. to=1 marks a job whose core never answers.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit to);
        exp_t e;
        bit   ok = 1'b0;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e.a = a;
            e.b = b;
            e.e = to && (a != 0) && (b != 0);
            if (e.e) e.g = '0;
            else if ((a == 0) || (b == 0)) e.g = a | b;
            else e.g = ref_gcd(a, b);
            exp_q.push_back(e);
        end
        step();
        bus.req_valid = 1'b0;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!bus.busy && !bus.rsp_valid && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        check("drain_in_budget", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_start"}, 32'(bus.start), 32'd0);
        check({pfx, "_a_in"}, bus.a_in, 32'd0);
        check({pfx, "_b_in"}, bus.b_in, 32'd0);
        check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({pfx, "_rsp_a"}, bus.rsp_a, 32'd0);
        check({pfx, "_rsp_b"}, bus.rsp_b, 32'd0);
        check({pfx, "_rsp_gcd"}, bus.rsp_gcd, 32'd0);
        check({pfx, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({pfx, "_busy"}, 32'(bus.busy), 32'd0);
        check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          sc;
        int          rc;
        int          n;
        bit          found;
        logic [31:0] ra, rb;

        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_reset_outputs("reset");

        // 1: basic job, start on the second cycle after acceptance
        sc = start_cnt;
        push(32'd48, 32'd18, 1'b0);
        @(negedge clk);
        check("t1_start_not_yet", 32'(bus.start), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("t1_start_launch", 32'(bus.start), 32'd1);
        check("t1_a_in", bus.a_in, 32'd48);
        check("t1_b_in", bus.b_in, 32'd18);
        wait_idle(100);
        check("t1_gcd", last_gcd, 32'd6);
        check("t1_one_start", 32'(start_cnt - sc), 32'd1);

        // 2: zero-operand bypass, no launch, in order
        sc = start_cnt;
        rc = rsp_cnt;
        push(32'd0, 32'd35, 1'b0);
        @(negedge clk);
        check("t2_rsp_not_yet", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t2_rsp_gcd", bus.rsp_gcd, 32'd35);
        step();
        push(32'd21, 32'd0, 1'b0);
        push(32'd0, 32'd0, 1'b0);
        wait_idle(100);
        check("t2_last_gcd", last_gcd, 32'd0);
        check("t2_no_start", 32'(start_cnt - sc), 32'd0);
        check("t2_rsp_count", 32'(rsp_cnt - rc), 32'd3);

        // 3: fill the FIFO behind a slow job
        core_delay = 12;
        rc = rsp_cnt;
        for (int i = 0; i < 5; i++) begin
            push(32'($urandom_range(1, 5000)), 32'($urandom_range(1, 5000)), 1'b0);
        end
        @(negedge clk);
        check("t3_req_ready_full", 32'(bus.req_ready), 32'd0);
        wait_idle(400);
        check("t3_rsp_count", 32'(rsp_cnt - rc), 32'd5);

        // 4: core never answers -> abort after 16 WAIT cycles
        core_never = 1'b1;
        push(32'd7, 32'd5, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.start) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_start_seen", 32'(found), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 40);
        // LAUNCH cycle, 16 WAIT cycles, then RESP
        check("t4_cycles_to_rsp", 32'(n), 32'd17);
        check("t4_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("t4_rsp_gcd", bus.rsp_gcd, 32'd0);
        step();
        wait_idle(100);
        core_never = 1'b0;

        // 5: response backpressure
        core_delay = 4;
        rdy_fix = 1'b0;
        push(32'd100, 32'd75, 1'b0);
        push(32'd9, 32'd6, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_rsp_seen", 32'(found), 32'd1);
        step();
        sc = start_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("t5_hold_gcd", bus.rsp_gcd, 32'd25);
            check("t5_hold_a", bus.rsp_a, 32'd100);
        end
        step();
        check("t5_no_second_start", 32'(start_cnt - sc), 32'd0);
        rdy_fix = 1'b1;
        wait_idle(200);
        check("t5_last_gcd", last_gcd, 32'd3);

        // spurious done outside WAIT is ignored
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("spur_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("spur_busy", 32'(bus.busy), 32'd0);
        end
        step();

        // 6: reset in the middle of WAIT drops the job
        core_delay = 10;
        rc = rsp_cnt;
        push(32'd1071, 32'd462, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.start) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_start_seen", 32'(found), 32'd1);
        repeat (3) step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("t6_reset");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("t6_no_rsp", 32'(rsp_cnt - rc), 32'd0);
        check("t6_idle_busy", 32'(bus.busy), 32'd0);
        core_delay = 3;
        push(32'd1071, 32'd462, 1'b0);
        wait_idle(100);
        check("t6_gcd", last_gcd, 32'd21);

        // randomized traffic with random response backpressure
        rand_rdy = 1'b1;
        rc = rsp_cnt;
        for (int i = 0; i < 16; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
            core_delay = int'($urandom_range(1, 12));
            push(ra, rb, 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(2000);
        check("rand_rsp_count", 32'(rsp_cnt - rc), 32'd16);
        rand_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
